// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   arb_state_t : arbiter lock state (idle / packet lock held)
//   idx_w()     : width of a requester index, never less than one bit
package uart_arb_pkg;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: returns a one-hot grant for the first set request bit
// found when scanning from 'start' upward, wrapping from N-1 back to 0.
// Ports:
//   req   in  N      request vector
//   start in  IDX_W  index to scan from (highest priority)
//   grant out N      one-hot winner, all zero when no request is set
module rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] start,
   output logic [N-1:0]     grant
);

   logic [N-1:0] rot;
   logic         found;
   int           hit;

   // Rotate so 'start' lands at bit 0, take the lowest set bit, rotate back.
   // Selects use constant indices so no wide dynamic index is needed.
   always_comb begin
      rot   = '0;
      grant = '0;
      hit   = 0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (j == ((i + int'(start)) % N)) rot[i] = req[j];
         end
      end
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            hit   = i;
            found = 1'b1;
         end
      end
      for (int j = 0; j < N; j++) begin
         if (found && (j == ((hit + int'(start)) % N))) grant[j] = 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx byte channel between NUM_REQ requesters. Round-robin
// arbitration with the grant locked for a whole packet (released by a beat
// with req_last_i set, or by the owner staying silent for IDLE_TIMEOUT
// cycles). A one-entry registered output stage drives uart_tx.
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous active-high reset
//   req_val_i    per-requester byte valid
//   req_data_i   requester i byte at [i*DW +: DW]
//   req_last_i   last byte of packet, releases the lock
//   req_rdy_o    per-requester ready, at most one bit set
//   uart_val_o   byte valid towards uart_tx
//   uart_data_o  byte towards uart_tx
//   uart_rdy_i   uart_tx ready
//   busy_o       lock held or output stage full
//   owner_o      current / last owner index
//   timeout_o    one-cycle pulse after a forced release
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int UART_DATA_WIDTH = 8,
   parameter int NUM_REQ         = 4,
   parameter int IDLE_TIMEOUT    = 1024,
   localparam int IDX_W          = idx_w(NUM_REQ)
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic [NUM_REQ-1:0]                 req_val_i,
   input  logic [NUM_REQ*UART_DATA_WIDTH-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]                 req_last_i,
   output logic [NUM_REQ-1:0]                 req_rdy_o,
   output logic                               uart_val_o,
   output logic [UART_DATA_WIDTH-1:0]         uart_data_o,
   input  logic                               uart_rdy_i,
   output logic                               busy_o,
   output logic [IDX_W-1:0]                   owner_o,
   output logic                               timeout_o
);

   localparam int DW    = UART_DATA_WIDTH;
   localparam int CNT_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LIM =
      (IDLE_TIMEOUT > 0) ? CNT_W'(IDLE_TIMEOUT - 1) : '0;

   arb_state_t        state, state_d;
   logic [IDX_W-1:0]  owner, owner_d;
   logic [IDX_W-1:0]  rr_ptr, rr_d;
   logic [IDX_W-1:0]  win_idx;
   logic [IDX_W-1:0]  ptr_after_owner;
   logic [NUM_REQ-1:0] grant;
   logic [CNT_W-1:0]  idle_cnt, cnt_d;
   logic              out_full;
   logic [DW-1:0]     out_data;
   logic              timeout_q;
   logic              fire;
   logic              accept;
   logic              owner_val;
   logic              owner_last;
   logic [DW-1:0]     owner_data;
   logic              slot_free;

   rr_pick #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req   (req_val_i),
      .start (rr_ptr),
      .grant (grant)
   );

   // One-hot grant to index, and the owner's request fields.
   always_comb begin
      win_idx    = '0;
      owner_val  = 1'b0;
      owner_last = 1'b0;
      owner_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) win_idx = IDX_W'(i);
         if (owner == IDX_W'(i)) begin
            owner_val  = req_val_i[i];
            owner_last = req_last_i[i];
            owner_data = req_data_i[i*DW +: DW];
         end
      end
   end

   assign ptr_after_owner = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
   // Accept while the stage drains so a packet streams without bubbles.
   assign slot_free = !out_full || uart_rdy_i;

   always_comb begin
      state_d   = state;
      owner_d   = owner;
      rr_d      = rr_ptr;
      cnt_d     = idle_cnt;
      fire      = 1'b0;
      accept    = 1'b0;
      req_rdy_o = '0;
      case (state)
         ARB_IDLE: begin
            if (|grant) begin
               state_d = ARB_LOCKED;
               owner_d = win_idx;
               cnt_d   = '0;
            end
         end
         ARB_LOCKED: begin
            // The timeout takes priority over a beat arriving in the same cycle.
            fire   = (IDLE_TIMEOUT != 0) && (idle_cnt == CNT_LIM);
            accept = !fire && owner_val && slot_free;
            for (int i = 0; i < NUM_REQ; i++) begin
               if (owner == IDX_W'(i)) req_rdy_o[i] = !fire && slot_free;
            end
            if (accept) begin
               cnt_d = '0;
            end else if (!owner_val && (IDLE_TIMEOUT != 0)) begin
               cnt_d = idle_cnt + 1'b1;
            end
            if (fire || (accept && owner_last)) begin
               state_d = ARB_IDLE;
               rr_d    = ptr_after_owner;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= ARB_IDLE;
      else       state <= state_d;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         owner     <= '0;
         rr_ptr    <= '0;
         idle_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         owner     <= owner_d;
         rr_ptr    <= rr_d;
         idle_cnt  <= cnt_d;
         timeout_q <= fire;
      end
   end

   // Output stage: data only changes on an accepted beat, which can only
   // happen when the stage is empty or uart_tx is taking the current byte.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_full <= 1'b0;
         out_data <= '0;
      end else if (accept) begin
         out_full <= 1'b1;
         out_data <= owner_data;
      end else if (uart_rdy_i) begin
         out_full <= 1'b0;
      end
   end

   assign uart_val_o  = out_full;
   assign uart_data_o = out_data;
   assign busy_o      = (state == ARB_LOCKED) || out_full;
   assign owner_o     = owner;
   assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a 4-requester instance with an
// 8-cycle idle timeout and a single-requester instance.
module tb_uart_tx_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_val;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_rdy;
   logic        uval;
   logic [7:0]  udata;
   logic        uart_rdy;
   logic        busy;
   logic [1:0]  owner;
   logic        to;

   logic        val1;
   logic [7:0]  data1;
   logic        last1;
   logic        rdy1;
   logic        uval1;
   logic [7:0]  udata1;
   logic        uart_rdy1;
   logic        busy1;
   logic        owner1;
   logic        to1;

   int n_cmp = 0;
   int n_bad = 0;

   uart_tx_arbiter #(
      .UART_DATA_WIDTH (8),
      .NUM_REQ         (4),
      .IDLE_TIMEOUT    (8)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_val_i   (req_val),
      .req_data_i  (req_data),
      .req_last_i  (req_last),
      .req_rdy_o   (req_rdy),
      .uart_val_o  (uval),
      .uart_data_o (udata),
      .uart_rdy_i  (uart_rdy),
      .busy_o      (busy),
      .owner_o     (owner),
      .timeout_o   (to)
   );

   uart_tx_arbiter #(
      .UART_DATA_WIDTH (8),
      .NUM_REQ         (1),
      .IDLE_TIMEOUT    (8)
   ) dut1 (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_val_i   (val1),
      .req_data_i  (data1),
      .req_last_i  (last1),
      .req_rdy_o   (rdy1),
      .uart_val_o  (uval1),
      .uart_data_o (udata1),
      .uart_rdy_i  (uart_rdy1),
      .busy_o      (busy1),
      .owner_o     (owner1),
      .timeout_o   (to1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, required finish before 100000 ns");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic do_reset();
      req_val = '0; req_data = '0; req_last = '0; uart_rdy = 1'b1;
      val1 = 1'b0; data1 = '0; last1 = 1'b0; uart_rdy1 = 1'b1;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_val = 4'b1111; req_data = 32'hFFFF_FFFF; req_last = '0; uart_rdy = 1'b1;
      val1 = 1'b1; data1 = 8'hFF; last1 = 1'b0; uart_rdy1 = 1'b1;
      step();
      smp();
      n_cmp++; if (req_rdy !== 4'b0000) begin n_bad++; $display("FAIL rst_rdy: got %b required 0000", req_rdy); end
      n_cmp++; if (uval !== 1'b0) begin n_bad++; $display("FAIL rst_uval: got %b required 0", uval); end
      n_cmp++; if (udata !== 8'h00) begin n_bad++; $display("FAIL rst_udata: got %h required 00", udata); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b required 0", busy); end
      n_cmp++; if (owner !== 2'd0) begin n_bad++; $display("FAIL rst_owner: got %0d required 0", owner); end
      n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL rst_to: got %b required 0", to); end
      n_cmp++; if ({rdy1, uval1, busy1, owner1, to1} !== 5'b0) begin n_bad++; $display("FAIL rst_dut1: got %b required 00000", {rdy1, uval1, busy1, owner1, to1}); end
   endtask

   task automatic test_single_packet();
      do_reset();
      uart_rdy = 1'b1; req_val = 4'b0001; req_data[7:0] = 8'h41; req_last = '0;
      smp();
      n_cmp++; if (req_rdy !== 4'b0000) begin n_bad++; $display("FAIL sp_c0_rdy: got %b required 0000", req_rdy); end
      step();
      smp();
      n_cmp++; if (req_rdy !== 4'b0001) begin n_bad++; $display("FAIL sp_c1_rdy: got %b required 0001", req_rdy); end
      step();
      req_data[7:0] = 8'h42;
      smp();
      n_cmp++; if ({uval, udata} !== {1'b1, 8'h41}) begin n_bad++; $display("FAIL sp_c2_out: got %b/%h required 1/41", uval, udata); end
      n_cmp++; if (req_rdy !== 4'b0001) begin n_bad++; $display("FAIL sp_c2_rdy: got %b required 0001", req_rdy); end
      step();
      req_data[7:0] = 8'h43; req_last[0] = 1'b1;
      smp();
      n_cmp++; if ({uval, udata} !== {1'b1, 8'h42}) begin n_bad++; $display("FAIL sp_c3_out: got %b/%h required 1/42", uval, udata); end
      step();
      req_val = '0; req_last = '0;
      smp();
      n_cmp++; if ({uval, udata} !== {1'b1, 8'h43}) begin n_bad++; $display("FAIL sp_c4_out: got %b/%h required 1/43", uval, udata); end
      n_cmp++; if ({req_rdy, busy} !== 5'b0000_1) begin n_bad++; $display("FAIL sp_c4_rdy_busy: got %b/%b required 0000/1", req_rdy, busy); end
      step();
      // Pointer now at 1: with 0 and 1 both requesting, 1 must win.
      req_val = 4'b0011; req_last = 4'b0011; req_data[15:8] = 8'h55;
      smp();
      n_cmp++; if ({uval, busy} !== 2'b00) begin n_bad++; $display("FAIL sp_c5_idle: got val/busy %b%b required 00", uval, busy); end
      step();
      smp();
      n_cmp++; if ({req_rdy, owner} !== {4'b0010, 2'd1}) begin n_bad++; $display("FAIL sp_rr_next: got rdy %b owner %0d required 0010 owner 1", req_rdy, owner); end
      step();
      req_val = '0; req_last = '0;
      smp();
      n_cmp++; if ({uval, udata} !== {1'b1, 8'h55}) begin n_bad++; $display("FAIL sp_c7_out: got %b/%h required 1/55", uval, udata); end
      step();
   endtask

   task automatic test_round_robin();
      do_reset();
      uart_rdy = 1'b1; req_val = 4'b1111; req_last = 4'b1111;
      req_data = 32'hA3A2_A1A0;
      for (int k = 0; k < 5; k++) begin
         smp();
         n_cmp++; if (req_rdy !== 4'b0000) begin n_bad++; $display("FAIL rr_idle%0d_rdy: got %b required 0000", k, req_rdy); end
         if (k > 0) begin
            n_cmp++; if ({uval, udata} !== {1'b1, 8'(8'hA0 + (k - 1) % 4)}) begin n_bad++; $display("FAIL rr_out%0d: got %b/%h required 1/%h", k, uval, udata, 8'(8'hA0 + (k - 1) % 4)); end
         end
         step();
         smp();
         n_cmp++; if (req_rdy !== 4'(1 << (k % 4))) begin n_bad++; $display("FAIL rr_grant%0d: got %b required %b", k, req_rdy, 4'(1 << (k % 4))); end
         n_cmp++; if (owner !== 2'(k % 4)) begin n_bad++; $display("FAIL rr_owner%0d: got %0d required %0d", k, owner, k % 4); end
         step();
      end
      req_val = '0; req_last = '0;
      step();
      step();
   endtask

   task automatic test_stall();
      do_reset();
      uart_rdy = 1'b1; req_val = 4'b0110; req_last = 4'b0100;
      req_data[15:8] = 8'h51; req_data[23:16] = 8'h61;
      smp();
      n_cmp++; if (req_rdy !== 4'b0000) begin n_bad++; $display("FAIL st_c0_rdy: got %b required 0000", req_rdy); end
      step();
      smp();
      n_cmp++; if ({req_rdy, owner} !== {4'b0010, 2'd1}) begin n_bad++; $display("FAIL st_grant1: got %b owner %0d required 0010 owner 1", req_rdy, owner); end
      step();
      uart_rdy = 1'b0; req_data[15:8] = 8'h52;
      for (int i = 0; i < 20; i++) begin
         smp();
         n_cmp++; if ({uval, udata, req_rdy, owner, busy} !== {1'b1, 8'h51, 4'b0000, 2'd1, 1'b1}) begin
            n_bad++; $display("FAIL st_hold%0d: got val %b data %h rdy %b owner %0d busy %b required 1 51 0000 1 1", i, uval, udata, req_rdy, owner, busy);
         end
         step();
      end
      uart_rdy = 1'b1;
      smp();
      n_cmp++; if (req_rdy !== 4'b0010) begin n_bad++; $display("FAIL st_resume_rdy: got %b required 0010", req_rdy); end
      step();
      req_data[15:8] = 8'h53; req_last[1] = 1'b1;
      smp();
      n_cmp++; if ({req_rdy, udata} !== {4'b0010, 8'h52}) begin n_bad++; $display("FAIL st_b2: got %b/%h required 0010/52", req_rdy, udata); end
      step();
      req_val[1] = 1'b0; req_last[1] = 1'b0;
      smp();
      n_cmp++; if ({req_rdy, udata} !== {4'b0000, 8'h53}) begin n_bad++; $display("FAIL st_gap: got %b/%h required 0000/53", req_rdy, udata); end
      step();
      smp();
      n_cmp++; if ({req_rdy, owner} !== {4'b0100, 2'd2}) begin n_bad++; $display("FAIL st_grant2: got %b owner %0d required 0100 owner 2", req_rdy, owner); end
      step();
      req_val = '0; req_last = '0;
      smp();
      n_cmp++; if ({uval, udata} !== {1'b1, 8'h61}) begin n_bad++; $display("FAIL st_out61: got %b/%h required 1/61", uval, udata); end
      step();
      step();
   endtask

   task automatic test_timeout();
      do_reset();
      uart_rdy = 1'b1; req_val = 4'b1001; req_last = 4'b1000;
      req_data[7:0] = 8'h71; req_data[31:24] = 8'h73;
      smp();
      step();
      smp();
      n_cmp++; if (req_rdy !== 4'b0001) begin n_bad++; $display("FAIL to_c1_rdy: got %b required 0001", req_rdy); end
      step();
      req_val[0] = 1'b0;
      for (int k = 2; k <= 8; k++) begin
         smp();
         n_cmp++; if ({req_rdy, to} !== {4'b0001, 1'b0}) begin n_bad++; $display("FAIL to_wait%0d: got rdy %b to %b required 0001 0", k, req_rdy, to); end
         step();
      end
      // Owner comes back exactly when the timeout fires: the timeout wins.
      req_val[0] = 1'b1; req_data[7:0] = 8'h72;
      smp();
      n_cmp++; if ({req_rdy, to} !== {4'b0000, 1'b0}) begin n_bad++; $display("FAIL to_fire_rdy: got rdy %b to %b required 0000 0", req_rdy, to); end
      step();
      smp();
      n_cmp++; if ({to, req_rdy, busy} !== {1'b1, 4'b0000, 1'b0}) begin n_bad++; $display("FAIL to_pulse: got to %b rdy %b busy %b required 1 0000 0", to, req_rdy, busy); end
      step();
      smp();
      n_cmp++; if ({req_rdy, owner, to} !== {4'b1000, 2'd3, 1'b0}) begin n_bad++; $display("FAIL to_next_grant: got rdy %b owner %0d to %b required 1000 3 0", req_rdy, owner, to); end
      step();
      req_val = '0; req_last = '0;
      step();
      step();
   endtask

   task automatic test_reset_drain();
      do_reset();
      uart_rdy = 1'b0; req_val = 4'b0100; req_data[23:16] = 8'h99; req_last = '0;
      smp();
      step();
      smp();
      n_cmp++; if (req_rdy !== 4'b0100) begin n_bad++; $display("FAIL rd_grant: got %b required 0100", req_rdy); end
      step();
      smp();
      n_cmp++; if ({uval, udata, busy} !== {1'b1, 8'h99, 1'b1}) begin n_bad++; $display("FAIL rd_full: got %b/%h/%b required 1/99/1", uval, udata, busy); end
      #1 rst = 1'b1;
      #1;
      n_cmp++; if ({uval, udata, req_rdy, busy, owner} !== {1'b0, 8'h00, 4'b0000, 1'b0, 2'd0}) begin
         n_bad++; $display("FAIL rd_async: got val %b data %h rdy %b busy %b owner %0d required 0 00 0000 0 0", uval, udata, req_rdy, busy, owner);
      end
      uart_rdy = 1'b1;
      step();
      step();
      rst = 1'b0;
      smp();
      n_cmp++; if ({req_rdy, uval} !== {4'b0000, 1'b0}) begin n_bad++; $display("FAIL rd_idle: got rdy %b val %b required 0000 0", req_rdy, uval); end
      step();
      smp();
      n_cmp++; if ({req_rdy, owner} !== {4'b0100, 2'd2}) begin n_bad++; $display("FAIL rd_regrant: got %b owner %0d required 0100 owner 2", req_rdy, owner); end
      step();
      req_val = '0;
      step();
      step();
   endtask

   task automatic test_single_requester();
      do_reset();
      uart_rdy1 = 1'b1; val1 = 1'b1; data1 = 8'hB1; last1 = 1'b0;
      smp();
      n_cmp++; if (rdy1 !== 1'b0) begin n_bad++; $display("FAIL n1_c0_rdy: got %b required 0", rdy1); end
      step();
      smp();
      n_cmp++; if (rdy1 !== 1'b1) begin n_bad++; $display("FAIL n1_c1_rdy: got %b required 1", rdy1); end
      step();
      data1 = 8'hB2; last1 = 1'b1;
      smp();
      n_cmp++; if ({rdy1, uval1, udata1} !== {1'b1, 1'b1, 8'hB1}) begin n_bad++; $display("FAIL n1_c2: got rdy %b out %b/%h required 1 1/B1", rdy1, uval1, udata1); end
      step();
      data1 = 8'hC1; last1 = 1'b0;
      smp();
      n_cmp++; if ({rdy1, uval1, udata1} !== {1'b0, 1'b1, 8'hB2}) begin n_bad++; $display("FAIL n1_gap: got rdy %b out %b/%h required 0 1/B2", rdy1, uval1, udata1); end
      step();
      smp();
      n_cmp++; if ({rdy1, uval1, owner1} !== {1'b1, 1'b0, 1'b0}) begin n_bad++; $display("FAIL n1_c4: got rdy %b val %b owner %b required 1 0 0", rdy1, uval1, owner1); end
      step();
      data1 = 8'hC2; last1 = 1'b1;
      smp();
      n_cmp++; if ({rdy1, udata1} !== {1'b1, 8'hC1}) begin n_bad++; $display("FAIL n1_c5: got rdy %b data %h required 1 C1", rdy1, udata1); end
      step();
      val1 = 1'b0; last1 = 1'b0;
      smp();
      n_cmp++; if ({rdy1, uval1, udata1} !== {1'b0, 1'b1, 8'hC2}) begin n_bad++; $display("FAIL n1_c6: got rdy %b out %b/%h required 0 1/C2", rdy1, uval1, udata1); end
      step();
   endtask

   initial begin
      test_reset();
      test_single_packet();
      test_round_robin();
      test_stall();
      test_timeout();
      test_reset_drain();
      test_single_requester();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
